// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: widths, memory depths,
// instruction field positions and opcodes.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int INSTR_W    = 32;
    localparam int IMEM_DEPTH = 1024;
    localparam int DMEM_DEPTH = 256;
    localparam int IMEM_AW    = 10;
    localparam int DMEM_AW    = 8;
    localparam int REG_AW     = 3;
    localparam int NUM_REGS   = 8;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 25;
    localparam int RS_MSB  = 24;
    localparam int RS_LSB  = 22;
    localparam int RT_MSB  = 21;
    localparam int RT_LSB  = 19;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LDI  = 4'h6,
        OP_IN   = 4'h7,
        OP_OUT  = 4'h8,
        OP_JMP  = 4'h9,
        OP_BEQZ = 4'hA,
        OP_LD   = 4'hB,
        OP_ST   = 4'hC,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        word_t             imm;
    } fields_t;

    function automatic fields_t decode(input instr_t i);
        fields_t f;
        f.op  = i[OP_MSB:OP_LSB];
        f.rd  = i[RD_MSB:RD_LSB];
        f.rs  = i[RS_MSB:RS_LSB];
        f.rt  = i[RT_MSB:RT_LSB];
        f.imm = i[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/cpu_fetch.sv
// Fetch unit: owns the PC, the next-PC mux and the instruction memory.
module cpu_fetch
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   halt,
    input  logic   taken,
    input  word_t  target,
    output instr_t instr
);

    word_t pc;
    word_t next_pc;
    word_t vec;

    cpu_imem instr_memory (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (pc[IMEM_AW+1:2]),
        .rdata (instr),
        .vec   (vec)
    );

    // Target low bits are kept in the PC but never reach the memory address.
    always_comb begin
        next_pc = pc + 16'd4;
        if (halt) begin
            next_pc = pc;
        end else if (taken) begin
            next_pc = target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= vec;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/cpu_imem.sv
// 1024 x 32 instruction memory: combinational read, word 0 doubles as the reset vector.
module cpu_imem
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  instr_t             wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output instr_t             rdata,
    output word_t              vec
);

    instr_t mem [0:IMEM_DEPTH-1];

    // Normally loaded from outside before reset; the write port is kept for completeness.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign vec   = mem[0][DATA_W-1:0];

endmodule

// File: rtl/cpu.sv
// Single-cycle 16-bit CPU top: decode, register file, ALU, data memory and output port.
module cpu
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  word_t in_port,
    output word_t out_port
);

    instr_t  instr;
    fields_t f;
    word_t   regs [0:NUM_REGS-1];
    word_t   dmem [0:DMEM_DEPTH-1];
    word_t   rs_val;
    word_t   rt_val;
    word_t   dmem_rdata;
    word_t   wr_data;
    logic    wr_en;
    logic    out_we;
    logic    dmem_we;
    logic    taken;
    logic    halt;
    logic    unused_rsvd;

    cpu_fetch fetch_unit (
        .clk    (clk),
        .rst    (rst),
        .halt   (halt),
        .taken  (taken),
        .target (f.imm),
        .instr  (instr)
    );

    assign f           = decode(instr);
    assign unused_rsvd = ^instr[18:16];
    assign rs_val      = regs[f.rs];
    assign rt_val      = regs[f.rt];
    assign dmem_rdata  = dmem[rs_val[DMEM_AW-1:0]];

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        out_we  = 1'b0;
        dmem_we = 1'b0;
        taken   = 1'b0;
        halt    = 1'b0;
        case (f.op)
            OP_ADD:  begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
            OP_SUB:  begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
            OP_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
            OP_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
            OP_ADDI: begin wr_en = 1'b1; wr_data = rs_val + f.imm; end
            OP_LDI:  begin wr_en = 1'b1; wr_data = f.imm; end
            OP_IN:   begin wr_en = 1'b1; wr_data = in_port; end
            OP_OUT:  out_we = 1'b1;
            OP_JMP:  taken = 1'b1;
            OP_BEQZ: taken = (rs_val == '0);
            OP_LD:   begin wr_en = 1'b1; wr_data = dmem_rdata; end
            OP_ST:   dmem_we = 1'b1;
            OP_HLT:  halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            out_port <= '0;
        end else begin
            if (wr_en) begin
                regs[f.rd] <= wr_data;
            end
            if (out_we) begin
                out_port <= rs_val;
            end
        end
    end

    // Data memory survives reset; only the store of a reset cycle is suppressed.
    always_ff @(posedge clk) begin
        if (rst && dmem_we) begin
            dmem[rs_val[DMEM_AW-1:0]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs with fixed expectations plus random programs
// checked cycle by cycle against an instruction-level model.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_port;
    logic [15:0] out_port;

    cpu dut (
        .clk      (clk),
        .rst      (rst),
        .in_port  (in_port),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    logic [15:0] last_out;

    logic [31:0] imem_m [0:1023];
    logic [15:0] regs_m [0:7];
    logic [15:0] dmem_m [0:255];
    logic [15:0] pc_m;
    logic [15:0] out_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [15:0] imm);
        return {op, rd, rs, rt, 3'b000, imm};
    endfunction

    task automatic put(input int w, input logic [31:0] v);
        imem_m[w] = v;
        dut.fetch_unit.instr_memory.mem[w] = v;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) put(i, 32'h0);
    endtask

    task automatic model_reset();
        pc_m  = imem_m[0][15:0];
        out_m = 16'h0;
        for (int i = 0; i < 8; i++) regs_m[i] = 16'h0;
    endtask

    task automatic model_exec(input logic [15:0] inval);
        logic [31:0] w;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a, b, imm, npc;
        w   = imem_m[pc_m[11:2]];
        op  = w[31:28];
        rd  = w[27:25];
        a   = regs_m[w[24:22]];
        b   = regs_m[w[21:19]];
        imm = w[15:0];
        npc = pc_m + 16'd4;
        case (op)
            4'h1: regs_m[rd] = a + b;
            4'h2: regs_m[rd] = a - b;
            4'h3: regs_m[rd] = a & b;
            4'h4: regs_m[rd] = a | b;
            4'h5: regs_m[rd] = a + imm;
            4'h6: regs_m[rd] = imm;
            4'h7: regs_m[rd] = inval;
            4'h8: out_m = a;
            4'h9: npc = imm;
            4'hA: if (a == 16'h0) npc = imm;
            4'hB: regs_m[rd] = dmem_m[a[7:0]];
            4'hC: dmem_m[a[7:0]] = b;
            4'hF: npc = pc_m;
            default: ;
        endcase
        pc_m = npc;
    endtask

    // One clock: drive away from the edge, advance the model, check after the edge.
    task automatic step(input logic r, input logic [15:0] inval);
        @(negedge clk);
        rst     = r;
        in_port = inval;
        if (!r) model_reset();
        else    model_exec(inval);
        exp_q.push_back(out_m);
        @(posedge clk);
        #1;
        check("out_port", {16'h0, out_port}, {16'h0, exp_q.pop_front()});
        check("pc", {16'h0, dut.fetch_unit.pc}, {16'h0, pc_m});
        if (out_port !== last_out) obs_q.push_back(out_port);
        last_out = out_port;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 16'($urandom));
    endtask

    task automatic load_loop_prog();
        clear_imem();
        put(0,  32'h0000_0040);
        put(16, enc(4'h6, 3'd1, 3'd0, 3'd0, 16'd3));
        put(17, enc(4'h5, 3'd1, 3'd1, 3'd0, 16'hFFFF));
        put(18, enc(4'h8, 3'd0, 3'd1, 3'd0, 16'h0));
        put(19, enc(4'hA, 3'd0, 3'd1, 3'd0, 16'h0054));
        put(20, enc(4'h9, 3'd0, 3'd0, 3'd0, 16'h0044));
        put(21, enc(4'hF, 3'd0, 3'd0, 3'd0, 16'h0));
    endtask

    initial begin
        logic [15:0] seq [3];
        rst      = 1'b0;
        in_port  = 16'h0;
        last_out = 16'h0;
        for (int i = 0; i < 256; i++) dmem_m[i] = 16'h0;
        for (int i = 0; i < 8; i++) regs_m[i] = 16'h0;

        // Reset vector and I/O loopback
        clear_imem();
        put(0,  32'h0000_0040);
        put(16, enc(4'h7, 3'd1, 3'd0, 3'd0, 16'h0));
        put(17, enc(4'h8, 3'd0, 3'd1, 3'd0, 16'h0));
        put(18, enc(4'hF, 3'd0, 3'd0, 3'd0, 16'h0));
        step(1'b0, 16'h0);
        check("reset_vector_pc", {16'h0, dut.fetch_unit.pc}, 32'h0040);
        check("reset_out", {16'h0, out_port}, 32'h0);
        step(1'b1, 16'd20);
        step(1'b1, 16'($urandom));
        check("loopback_out", {16'h0, out_port}, 32'h0014);
        run(3);
        check("loopback_hold", {16'h0, out_port}, 32'h0014);
        check("hlt_pc_frozen", {16'h0, dut.fetch_unit.pc}, 32'h0048);

        // ALU wrap-around
        clear_imem();
        put(0,  32'h0000_0040);
        put(16, enc(4'h6, 3'd2, 3'd0, 3'd0, 16'd5));
        put(17, enc(4'h6, 3'd3, 3'd0, 3'd0, 16'd7));
        put(18, enc(4'h2, 3'd4, 3'd2, 3'd3, 16'h0));
        put(19, enc(4'h8, 3'd0, 3'd4, 3'd0, 16'h0));
        put(20, enc(4'h5, 3'd5, 3'd4, 3'd0, 16'd3));
        put(21, enc(4'h8, 3'd0, 3'd5, 3'd0, 16'h0));
        put(22, enc(4'hF, 3'd0, 3'd0, 3'd0, 16'h0));
        step(1'b0, 16'h0);
        run(4);
        check("alu_sub_out", {16'h0, out_port}, 32'hFFFE);
        run(2);
        check("alu_addi_out", {16'h0, out_port}, 32'h0001);

        // Countdown loop
        load_loop_prog();
        step(1'b0, 16'h0);
        obs_q.delete();
        run(20);
        seq = '{16'd2, 16'd1, 16'd0};
        check("loop_out_count", obs_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            check("loop_out_seq", {16'h0, (i < obs_q.size()) ? obs_q[i] : 16'hDEAD}, {16'h0, seq[i]});
        check("loop_hlt_pc", {16'h0, dut.fetch_unit.pc}, 32'h0054);

        // Mid-run reset lands on an ADDI write-back
        step(1'b0, 16'h0);
        run(5);
        check("mid_before_out", {16'h0, out_port}, 32'h0002);
        step(1'b0, 16'h0);
        check("mid_reset_pc", {16'h0, dut.fetch_unit.pc}, 32'h0040);
        check("mid_reset_out", {16'h0, out_port}, 32'h0);
        for (int i = 0; i < 8; i++)
            check($sformatf("mid_reset_r%0d", i), {16'h0, dut.regs[i]}, 32'h0);
        run(20);
        check("rerun_pc", {16'h0, dut.fetch_unit.pc}, 32'h0054);

        // Data memory store then load
        clear_imem();
        put(0,  32'h0000_0040);
        put(16, enc(4'h6, 3'd1, 3'd0, 3'd0, 16'h0010));
        put(17, enc(4'h6, 3'd2, 3'd0, 3'd0, 16'hBEEF));
        put(18, enc(4'hC, 3'd0, 3'd1, 3'd2, 16'h0));
        put(19, enc(4'hB, 3'd3, 3'd1, 3'd0, 16'h0));
        put(20, enc(4'h8, 3'd0, 3'd3, 3'd0, 16'h0));
        put(21, enc(4'hF, 3'd0, 3'd0, 3'd0, 16'h0));
        step(1'b0, 16'h0);
        run(5);
        check("mem_beef_out", {16'h0, out_port}, 32'hBEEF);

        // Vector pointing at word 0: the vector word executes as a NOP
        clear_imem();
        put(0, 32'h0000_0000);
        put(1, enc(4'h6, 3'd1, 3'd0, 3'd0, 16'h0055));
        put(2, enc(4'h8, 3'd0, 3'd1, 3'd0, 16'h0));
        put(3, enc(4'hF, 3'd0, 3'd0, 3'd0, 16'h0));
        step(1'b0, 16'h0);
        check("vec0_pc", {16'h0, dut.fetch_unit.pc}, 32'h0000);
        run(3);
        check("vec0_out", {16'h0, out_port}, 32'h0055);
        check("vec0_pc_after", {16'h0, dut.fetch_unit.pc}, 32'h000C);

        // Zero all of data memory so random loads have a known history
        clear_imem();
        put(0,  32'h0000_0040);
        put(16, enc(4'h6, 3'd1, 3'd0, 3'd0, 16'h0));
        put(17, enc(4'h6, 3'd2, 3'd0, 3'd0, 16'h0));
        put(18, enc(4'h6, 3'd5, 3'd0, 3'd0, 16'h0100));
        put(19, enc(4'hC, 3'd0, 3'd1, 3'd2, 16'h0));
        put(20, enc(4'h5, 3'd1, 3'd1, 3'd0, 16'd1));
        put(21, enc(4'h2, 3'd4, 3'd1, 3'd5, 16'h0));
        put(22, enc(4'hA, 3'd0, 3'd4, 3'd0, 16'h0060));
        put(23, enc(4'h9, 3'd0, 3'd0, 3'd0, 16'h004C));
        put(24, enc(4'hF, 3'd0, 3'd0, 3'd0, 16'h0));
        step(1'b0, 16'h0);
        run(1300);
        check("dclear_pc", {16'h0, dut.fetch_unit.pc}, 32'h0060);

        // Random programs with occasional mid-run resets
        for (int p = 0; p < 20; p++) begin
            logic [31:0] w;
            logic [3:0]  op;
            clear_imem();
            put(0, 32'h0000_0040);
            for (int k = 16; k < 64; k++) begin
                w  = $urandom;
                op = w[31:28];
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h5;
                w[31:28] = op;
                if (op == 4'h9 || op == 4'hA)
                    w[15:0] = 16'($urandom_range(16, 63) * 4 + $urandom_range(0, 3));
                put(k, w);
            end
            step(1'b0, 16'h0);
            for (int c = 0; c < 150; c++)
                step($urandom_range(0, 99) != 0, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
